// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding encodings, hazard FSM states and the NOP word.
package pipe_pkg;

  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_WB  = 2'b01;
  localparam logic [1:0]  FWD_MEM = 2'b10;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  // MEM result is younger than WB, so it wins a double match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd,
                                         input logic [4:0] w_rd,
                                         input logic       m_we,
                                         input logic       w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
      return FWD_MEM;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding selects, purely combinational.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] E_rs1,
  input  logic [4:0] E_rs2,
  input  logic [4:0] M_rd,
  input  logic [4:0] W_rd,
  input  logic       M_reg_write,
  input  logic       W_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(E_rs1, M_rd, W_rd, M_reg_write, W_reg_write);
  assign fwd_b = fwd_sel(E_rs2, M_rd, W_rd, M_reg_write, W_reg_write);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: multi-cycle wait FSM, redirect
// bookkeeping, load-use detection and forwarding.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] D_rs1,
  input  logic [4:0] D_rs2,
  input  logic [4:0] E_rs1,
  input  logic [4:0] E_rs2,
  input  logic [4:0] E_rd,
  input  logic       E_is_load,
  input  logic       E_is_mc,
  input  logic       E_pc_src,
  input  logic [4:0] M_rd,
  input  logic [4:0] W_rd,
  input  logic       M_reg_write,
  input  logic       W_reg_write,
  input  logic       imem_ready,
  output logic       F_stall,
  output logic       D_stall,
  output logic       E_stall,
  output logic       D_flush,
  output logic       E_flush,
  output logic       M_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mc_done,
  output logic       busy
);

  localparam logic [5:0] CNT_INIT = 6'(MC_LAT - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       redirect_pend_q, redirect_pend_d;
  logic       mc_done_q, mc_done_d;
  logic       lu, redirect;

  assign lu = E_is_load && (E_rd != 5'd0) && ((E_rd == D_rs1) || (E_rd == D_rs2));
  assign redirect = E_pc_src && !E_is_mc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= RUN;
      cnt_q           <= 6'd0;
      redirect_pend_q <= 1'b0;
      mc_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      redirect_pend_q <= redirect_pend_d;
      mc_done_q       <= mc_done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    redirect_pend_d = redirect_pend_q;
    mc_done_d       = 1'b0;
    F_stall         = 1'b0;
    D_stall         = 1'b0;
    E_stall         = 1'b0;
    D_flush         = 1'b0;
    E_flush         = 1'b0;
    M_flush         = 1'b0;

    case (state_q)
      MC_WAIT: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        E_stall = 1'b1;
        M_flush = 1'b1;
        if (cnt_q == 6'd0) begin
          state_d   = RUN;
          mc_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        if (E_is_mc) begin
          state_d = MC_WAIT;
          cnt_d   = CNT_INIT;
        end
        if (redirect) begin
          D_flush         = 1'b1;
          E_flush         = 1'b1;
          redirect_pend_d = !imem_ready;
        end else if (lu) begin
          F_stall = 1'b1;
          D_stall = 1'b1;
          E_flush = 1'b1;
        end else begin
          if (!imem_ready) begin
            F_stall = 1'b1;
            D_flush = 1'b1;
          end
          // First valid fetch after a stalled redirect is still wrong-path.
          if (redirect_pend_q && imem_ready) begin
            D_flush         = 1'b1;
            redirect_pend_d = 1'b0;
          end
        end
      end
    endcase

    if (!rst_n) begin
      F_stall = 1'b0;
      D_stall = 1'b0;
      E_stall = 1'b0;
      D_flush = 1'b0;
      E_flush = 1'b0;
      M_flush = 1'b0;
    end
  end

  assign mc_done = mc_done_q;
  assign busy    = (state_q == MC_WAIT);

  fwd_unit u_fwd_unit (
    .E_rs1       (E_rs1),
    .E_rs2       (E_rs2),
    .M_rd        (M_rd),
    .W_rd        (W_rd),
    .M_reg_write (M_reg_write),
    .W_reg_write (W_reg_write),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall scheduler for the five-stage RV32 pipeline. Generates the stall and flush controls that sequence the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX-stage forwarding selects. Owns three sequential elements:
- a multi-cycle-execute wait FSM, for iterative ops such as divide;
- a pending-redirect flag, used when a branch resolves while instruction memory is still busy;
- a one-cycle completion pulse.

## Interface
Parameters:
- MC_LAT, default 4: EX-stage occupancy in cycles of a multi-cycle op; legal range 1..63.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- D_rs1, D_rs2  in  5  source registers of the instruction in ID
- E_rs1, E_rs2, E_rd  in  5  source and destination registers of the instruction in EX
- E_is_load  in  1  EX holds a load
- E_is_mc  in  1  EX holds a multi-cycle op
- E_pc_src  in  1  EX resolved a taken branch or jump
- M_rd, W_rd  in  5  destination registers in MEM and WB
- M_reg_write, W_reg_write  in  1  MEM and WB write the register file
- imem_ready  in  1  fetch data valid this cycle
- F_stall, D_stall, E_stall  out  1  hold the PC, IF/ID and ID/EX registers respectively
- D_flush, E_flush, M_flush  out  1  load a NOP into IF/ID, ID/EX and EX/MEM respectively
- fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = WB result, 10 = MEM result
- mc_done  out  1  registered one-cycle pulse; the multi-cycle result is valid in EX
- busy  out  1  FSM is in MC_WAIT

## Operation
FSM states: RUN and MC_WAIT. cnt is a 6-bit down-counter. redirect_pend is a flag.

- **RUN with E_is_mc = 1:** the FSM enters MC_WAIT and loads cnt = MC_LAT-1. When MC_LAT = 1, MC_WAIT lasts exactly one cycle.
- **In MC_WAIT:**
  - F_stall, D_stall and E_stall are 1, and M_flush is 1.
  - cnt decrements each cycle.
  - When cnt = 0, the FSM returns to RUN. mc_done is 1 in the following cycle.
  - The stalls are released in the cycle the FSM is in RUN again.
- **Load-use hazard** is the condition lu = E_is_load & (E_rd ≠ 0) & (E_rd == D_rs1 | E_rd == D_rs2), evaluated only in RUN. When lu = 1: F_stall = 1, D_stall = 1, E_flush = 1.
- **Redirect** is E_pc_src = 1 in RUN with E_is_mc = 0: D_flush = 1 and E_flush = 1; F_stall and D_stall are forced to 0.
  - If imem_ready = 0 in the same cycle, redirect_pend is set to 1.
- **Fetch wait** (imem_ready = 0): F_stall = 1. D_flush = 1 only if D_stall = 0.
  - The pipeline never asserts D_flush together with D_stall, except on a redirect.
- **Pending redirect:** if redirect_pend = 1 and imem_ready = 1, D_flush = 1 (the wrong-path fetch is discarded) and redirect_pend is cleared.
- **Priority:** MC_WAIT > redirect > load-use > fetch wait.
  - E_pc_src is ignored while in MC_WAIT or while E_is_mc = 1; the two never coexist legally.
  - E_is_mc is ignored while already in MC_WAIT.
- **Forwarding select for fwd_a:**
  - 10 if M_reg_write & (M_rd ≠ 0) & (M_rd == E_rs1);
  - else 01 if W_reg_write & (W_rd ≠ 0) & (W_rd == E_rs1);
  - else 00.
  - MEM beats WB on a double match. fwd_b is identical using E_rs2.

## Timing
- Stall, flush and forward outputs are combinational from the inputs, state and redirect_pend; they are valid in the same cycle as the inputs.
- mc_done is registered.
- **Reset:** while rst_n = 0 on a clk edge, state = RUN, cnt = 0, redirect_pend = 0, mc_done = 0.
  - All combinational stall and flush outputs are forced to 0 while rst_n = 0.
  - Reset during MC_WAIT aborts the op and no mc_done is produced.
- A multi-cycle op occupies EX for exactly MC_LAT stall cycles.
- **Load-use:** exactly one bubble, with no FSM involvement.
- **Redirect:** two bubbles. A third bubble is added if redirect_pend was set.

## Structure
- Shared package pipe_pkg holds:
  - fwd encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the state enum RUN/MC_WAIT;
  - the NOP constant 32'h00000013, for the pipeline registers.
- Natural sub-module: fwd_unit (combinational fwd_a/fwd_b), instantiated once. The FSM, counter and flags stay in the top module.

## Test plan
- Load-use: E_is_load = 1, E_rd = 5, D_rs2 = 5 -> one cycle of F_stall = D_stall = E_flush = 1; the next cycle is all 0.
- Multi-cycle: MC_LAT = 4, E_is_mc pulsed -> busy = 1 and stalls + M_flush = 1 for 4 cycles; mc_done = 1 on the 5th cycle; E_pc_src = 1 during the wait has no effect.
- Redirect with imem_ready = 0: D_flush = E_flush = 1 and redirect_pend = 1; when imem_ready = 1 two cycles later -> D_flush = 1 for one cycle and redirect_pend = 0.
- Forwarding: M_rd = W_rd = 7 with both write enables set and E_rs1 = 7 -> fwd_a = 10; the same with M_rd = 0 -> fwd_a = 01; E_rs1 = 0 -> fwd_a = 00.
- Simultaneous redirect + load-use: E_pc_src = 1 and lu = 1 -> F_stall = 0, D_flush = E_flush = 1.
- Reset in MC_WAIT: rst_n = 0 in cycle 2 of a 4-cycle op -> busy = 0 and all stalls 0 next cycle; mc_done never asserts.
